// File: rtl/llki_pkg.sv
`default_nettype none
// ============================================================================
// Module      : llki_pkg
// Description : LLKI adapter types: TL-UL opcodes, adapter state encoding,
//               latched A-channel request struct and request-check helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package llki_pkg;

    import top_pkg::*;

    // A-channel opcodes
    localparam logic [2:0] TL_PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] TL_GET              = 3'd4;

    // D-channel opcodes
    localparam logic [2:0] TL_ACCESS_ACK       = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA  = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } adapter_state_e;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [TL_SZW-1:0] size;
        logic [TL_AIW-1:0] source;
        logic [TL_AW-1:0]  address;
        logic [TL_DBW-1:0] mask;
        logic [TL_DW-1:0]  data;
    } tl_a_req_t;

    // Only the three supported opcodes are accepted as legal accesses
    function automatic logic tl_a_opcode_legal(input logic [2:0] op);
        return (op == TL_PUT_FULL_DATA) || (op == TL_PUT_PARTIAL_DATA) || (op == TL_GET);
    endfunction

    // Address must be a multiple of 2^size; size is at most 8 bytes here
    function automatic logic tl_a_misaligned(input logic [TL_SZW-1:0] size,
                                             input logic [2:0]        addr_lo);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = addr_lo[0];
            2'd2:    mis = |addr_lo[1:0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage : llki_pkg
`default_nettype wire

// File: rtl/top_pkg.sv
`default_nettype none
// ============================================================================
// Module      : top_pkg
// Description : Shared TileLink-UL bus widths for the SROT crossbar fabric.
// Revision    : 1.0 - initial release
// ============================================================================
package top_pkg;

    localparam int TL_DW  = 64;
    localparam int TL_AW  = 32;
    localparam int TL_AIW = 4;
    localparam int TL_DIW = 2;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;

endpackage : top_pkg
`default_nettype wire

// File: rtl/llki_tlul_reg_adapter.sv
`default_nettype none
// ============================================================================
// Module      : llki_tlul_reg_adapter
// Description : TL-UL device adapter for the LLKI SROT register space. Takes
//               one A request at a time, issues a single-cycle register
//               strobe and returns the registered result on the D channel.
// Revision    : 1.0 - initial release
// ============================================================================
module llki_tlul_reg_adapter
    import top_pkg::*;
    import llki_pkg::*;
#(
    parameter int RegAw = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              tl_a_valid_i,
    output logic              tl_a_ready_o,
    input  logic [2:0]        tl_a_opcode_i,
    input  logic [TL_SZW-1:0] tl_a_size_i,
    input  logic [TL_AIW-1:0] tl_a_source_i,
    input  logic [TL_AW-1:0]  tl_a_address_i,
    input  logic [TL_DBW-1:0] tl_a_mask_i,
    input  logic [TL_DW-1:0]  tl_a_data_i,

    output logic              tl_d_valid_o,
    input  logic              tl_d_ready_i,
    output logic [2:0]        tl_d_opcode_o,
    output logic [TL_SZW-1:0] tl_d_size_o,
    output logic [TL_AIW-1:0] tl_d_source_o,
    output logic [TL_DIW-1:0] tl_d_sink_o,
    output logic [TL_DW-1:0]  tl_d_data_o,
    output logic              tl_d_error_o,

    output logic              reg_we_o,
    output logic              reg_re_o,
    output logic [RegAw-1:0]  reg_addr_o,
    output logic [TL_DW-1:0]  reg_wdata_o,
    output logic [TL_DBW-1:0] reg_be_o,
    input  logic [TL_DW-1:0]  reg_rdata_i,
    input  logic              reg_error_i
);

    adapter_state_e    state_q,     state_d;
    logic              a_ready_q,   a_ready_d;
    tl_a_req_t         req_q,       req_d;
    logic              reg_we_q,    reg_we_d;
    logic              reg_re_q,    reg_re_d;
    logic              d_valid_q,   d_valid_d;
    logic [2:0]        d_opcode_q,  d_opcode_d;
    logic [TL_SZW-1:0] d_size_q,    d_size_d;
    logic [TL_AIW-1:0] d_source_q,  d_source_d;
    logic [TL_DW-1:0]  d_data_q,    d_data_d;
    logic              d_error_q,   d_error_d;

    logic              a_fire;
    logic              a_legal;
    logic              a_is_get;
    logic              req_is_get;

    // a_ready_q is only ever set while in IDLE, so it alone qualifies acceptance
    assign a_fire     = tl_a_valid_i & a_ready_q;
    assign a_legal    = tl_a_opcode_legal(tl_a_opcode_i) &
                        ~tl_a_misaligned(tl_a_size_i, tl_a_address_i[2:0]);
    assign a_is_get   = (tl_a_opcode_i == TL_GET);
    assign req_is_get = (req_q.opcode == TL_GET);

    // Next-state and next-output computation for the adapter FSM
    always_comb begin
        state_d    = state_q;
        a_ready_d  = a_ready_q;
        req_d      = req_q;
        reg_we_d   = 1'b0;
        reg_re_d   = 1'b0;
        d_valid_d  = d_valid_q;
        d_opcode_d = d_opcode_q;
        d_size_d   = d_size_q;
        d_source_d = d_source_q;
        d_data_d   = d_data_q;
        d_error_d  = d_error_q;

        case (state_q)
            ST_IDLE: begin
                if (a_fire) begin
                    req_d.opcode  = tl_a_opcode_i;
                    req_d.size    = tl_a_size_i;
                    req_d.source  = tl_a_source_i;
                    req_d.address = tl_a_address_i;
                    req_d.mask    = tl_a_mask_i;
                    req_d.data    = tl_a_data_i;
                    a_ready_d     = 1'b0;
                    if (a_legal) begin
                        reg_we_d = ~a_is_get;
                        reg_re_d = a_is_get;
                        state_d  = ST_ACCESS;
                    end else begin
                        // Rejected request skips the register file entirely
                        d_valid_d  = 1'b1;
                        d_opcode_d = a_is_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
                        d_size_d   = tl_a_size_i;
                        d_source_d = tl_a_source_i;
                        d_data_d   = '0;
                        d_error_d  = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end

            ST_ACCESS: begin
                // Register file answers in the same cycle as the strobe
                d_valid_d  = 1'b1;
                d_opcode_d = req_is_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
                d_size_d   = req_q.size;
                d_source_d = req_q.source;
                d_data_d   = req_is_get ? reg_rdata_i : '0;
                d_error_d  = reg_error_i;
                state_d    = ST_RESP;
            end

            ST_RESP: begin
                if (tl_d_ready_i) begin
                    d_valid_d = 1'b0;
                    a_ready_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                d_valid_d = 1'b0;
                a_ready_d = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            a_ready_q  <= 1'b0;
            req_q      <= '0;
            reg_we_q   <= 1'b0;
            reg_re_q   <= 1'b0;
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_data_q   <= '0;
            d_error_q  <= 1'b0;
        end else if (state_q == ST_IDLE && !a_ready_q && !d_valid_q) begin
            // First cycle out of reset: open the A channel
            state_q    <= ST_IDLE;
            a_ready_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            a_ready_q  <= a_ready_d;
            req_q      <= req_d;
            reg_we_q   <= reg_we_d;
            reg_re_q   <= reg_re_d;
            d_valid_q  <= d_valid_d;
            d_opcode_q <= d_opcode_d;
            d_size_q   <= d_size_d;
            d_source_q <= d_source_d;
            d_data_q   <= d_data_d;
            d_error_q  <= d_error_d;
        end
    end

    // Bits of the latched address that never reach the register offset
    logic unused_req_addr;
    assign unused_req_addr = ^{req_q.address[TL_AW-1:RegAw], req_q.address[2:0]};

    assign tl_a_ready_o  = a_ready_q;

    assign tl_d_valid_o  = d_valid_q;
    assign tl_d_opcode_o = d_opcode_q;
    assign tl_d_size_o   = d_size_q;
    assign tl_d_source_o = d_source_q;
    assign tl_d_sink_o   = '0;
    assign tl_d_data_o   = d_data_q;
    assign tl_d_error_o  = d_error_q;

    assign reg_we_o      = reg_we_q;
    assign reg_re_o      = reg_re_q;
    assign reg_addr_o    = {req_q.address[RegAw-1:3], 3'b000};
    assign reg_wdata_o   = req_q.data;
    assign reg_be_o      = req_q.mask;

endmodule : llki_tlul_reg_adapter
`default_nettype wire

// File: tb/tb_llki_tlul_reg_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_llki_tlul_reg_adapter
// Description : Directed bench for the LLKI TL-UL register adapter; expected
//               D responses are queued at request time and popped on output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_llki_tlul_reg_adapter;

    import top_pkg::*;

    localparam int REG_AW = 8;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [TL_SZW-1:0] size;
        logic [TL_AIW-1:0] source;
        logic [TL_DW-1:0]  data;
        logic              error;
    } exp_rsp_t;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              tl_a_valid_i = 1'b0;
    logic              tl_a_ready_o;
    logic [2:0]        tl_a_opcode_i = '0;
    logic [TL_SZW-1:0] tl_a_size_i = '0;
    logic [TL_AIW-1:0] tl_a_source_i = '0;
    logic [TL_AW-1:0]  tl_a_address_i = '0;
    logic [TL_DBW-1:0] tl_a_mask_i = '0;
    logic [TL_DW-1:0]  tl_a_data_i = '0;
    logic              tl_d_valid_o;
    logic              tl_d_ready_i = 1'b1;
    logic [2:0]        tl_d_opcode_o;
    logic [TL_SZW-1:0] tl_d_size_o;
    logic [TL_AIW-1:0] tl_d_source_o;
    logic [TL_DIW-1:0] tl_d_sink_o;
    logic [TL_DW-1:0]  tl_d_data_o;
    logic              tl_d_error_o;
    logic              reg_we_o;
    logic              reg_re_o;
    logic [REG_AW-1:0] reg_addr_o;
    logic [TL_DW-1:0]  reg_wdata_o;
    logic [TL_DBW-1:0] reg_be_o;
    logic [TL_DW-1:0]  reg_rdata_i = '0;
    logic              reg_error_i = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    exp_rsp_t sb[$];

    always #5 clk = ~clk;

    llki_tlul_reg_adapter #(.RegAw(REG_AW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .tl_a_valid_i   (tl_a_valid_i),
        .tl_a_ready_o   (tl_a_ready_o),
        .tl_a_opcode_i  (tl_a_opcode_i),
        .tl_a_size_i    (tl_a_size_i),
        .tl_a_source_i  (tl_a_source_i),
        .tl_a_address_i (tl_a_address_i),
        .tl_a_mask_i    (tl_a_mask_i),
        .tl_a_data_i    (tl_a_data_i),
        .tl_d_valid_o   (tl_d_valid_o),
        .tl_d_ready_i   (tl_d_ready_i),
        .tl_d_opcode_o  (tl_d_opcode_o),
        .tl_d_size_o    (tl_d_size_o),
        .tl_d_source_o  (tl_d_source_o),
        .tl_d_sink_o    (tl_d_sink_o),
        .tl_d_data_o    (tl_d_data_o),
        .tl_d_error_o   (tl_d_error_o),
        .reg_we_o       (reg_we_o),
        .reg_re_o       (reg_re_o),
        .reg_addr_o     (reg_addr_o),
        .reg_wdata_o    (reg_wdata_o),
        .reg_be_o       (reg_be_o),
        .reg_rdata_i    (reg_rdata_i),
        .reg_error_i    (reg_error_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) at negedges for the A channel to open
    task automatic wait_a_ready(input string tag);
        int i;
        for (i = 0; i < 20 && tl_a_ready_o !== 1'b1; i++) @(negedge clk);
        if (i == 20) chk({tag, "_a_ready_timeout"}, 64'(tl_a_ready_o), 64'd1);
    endtask

    // One full A->strobe->D transaction; hold = cycles of D backpressure
    task automatic do_txn(input string tag, input logic [2:0] op, input logic [1:0] size,
                          input logic [3:0] src, input logic [31:0] addr, input logic [7:0] mask,
                          input logic [63:0] wdata, input logic [63:0] rdata, input logic rerr,
                          input int hold);
        logic     is_get;
        logic     aligned;
        logic     legal;
        logic     [31:0] amask;
        exp_rsp_t e;
        exp_rsp_t got;

        is_get  = (op == 3'd4);
        amask   = (32'd1 << size) - 32'd1;
        aligned = ((addr & amask) == 32'd0);
        legal   = (op == 3'd0 || op == 3'd1 || op == 3'd4) && aligned;
        e.opcode = is_get ? 3'd1 : 3'd0;
        e.size   = size;
        e.source = src;
        e.data   = (legal && is_get) ? rdata : 64'd0;
        e.error  = legal ? rerr : 1'b1;
        sb.push_back(e);

        wait_a_ready(tag);
        tl_a_valid_i   = 1'b1;
        tl_a_opcode_i  = op;
        tl_a_size_i    = size;
        tl_a_source_i  = src;
        tl_a_address_i = addr;
        tl_a_mask_i    = mask;
        tl_a_data_i    = wdata;
        reg_rdata_i    = rdata;
        reg_error_i    = rerr;
        tl_d_ready_i   = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        tl_a_valid_i   = 1'b0;
        tl_a_data_i    = '0;

        // Cycle N+1
        chk({tag, "_we"}, 64'(reg_we_o), 64'(legal && !is_get));
        chk({tag, "_re"}, 64'(reg_re_o), 64'(legal && is_get));
        chk({tag, "_a_ready_busy"}, 64'(tl_a_ready_o), 64'd0);
        if (legal) begin
            chk({tag, "_addr"}, 64'(reg_addr_o), 64'(addr[7:0] & 8'hF8));
            chk({tag, "_be"}, 64'(reg_be_o), 64'(mask));
            if (!is_get) chk({tag, "_wdata"}, reg_wdata_o, wdata);
            chk({tag, "_d_valid_early"}, 64'(tl_d_valid_o), 64'd0);
            @(negedge clk);
            // Cycle N+2: strobe must be gone
            chk({tag, "_strobe_once"}, 64'({reg_we_o, reg_re_o}), 64'd0);
        end
        reg_rdata_i = '0;
        reg_error_i = 1'b0;
        chk({tag, "_d_valid"}, 64'(tl_d_valid_o), 64'd1);

        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_valid"}, 64'(tl_d_valid_o), 64'd1);
            chk({tag, "_hold_a_ready"}, 64'(tl_a_ready_o), 64'd0);
            chk({tag, "_hold_data"}, tl_d_data_o, e.data);
            chk({tag, "_hold_err"}, 64'(tl_d_error_o), 64'(e.error));
            @(negedge clk);
        end
        tl_d_ready_i = 1'b1;

        got = sb.pop_front();
        chk({tag, "_d_opcode"}, 64'(tl_d_opcode_o), 64'(got.opcode));
        chk({tag, "_d_size"}, 64'(tl_d_size_o), 64'(got.size));
        chk({tag, "_d_source"}, 64'(tl_d_source_o), 64'(got.source));
        chk({tag, "_d_data"}, tl_d_data_o, got.data);
        chk({tag, "_d_error"}, 64'(tl_d_error_o), 64'(got.error));
        chk({tag, "_d_sink"}, 64'(tl_d_sink_o), 64'd0);

        @(negedge clk);
        chk({tag, "_d_valid_done"}, 64'(tl_d_valid_o), 64'd0);
        chk({tag, "_a_ready_back"}, 64'(tl_a_ready_o), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_ready", 64'(tl_a_ready_o), 64'd0);
        chk("rst_d_valid", 64'(tl_d_valid_o), 64'd0);
        chk("rst_strobes", 64'({reg_we_o, reg_re_o}), 64'd0);
        chk("rst_d_data", tl_d_data_o, 64'd0);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rel_a_ready", 64'(tl_a_ready_o), 64'd1);

        do_txn("wr_full", 3'd0, 2'd3, 4'd3, 32'h08, 8'hFF, 64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0, 0);
        do_txn("rd", 3'd4, 2'd3, 4'd5, 32'h08, 8'hFF, 64'h0, 64'h12345678_9ABCDEF0, 1'b0, 0);
        do_txn("wr_part", 3'd1, 2'd2, 4'd1, 32'h10, 8'h0F, 64'h0000_0000_A5A5_5A5A, 64'h0, 1'b0, 0);
        do_txn("rd_misal", 3'd4, 2'd3, 4'd2, 32'h04, 8'hFF, 64'h0, 64'hFFFF_0000_FFFF_0000, 1'b0, 0);
        do_txn("bad_op", 3'd2, 2'd3, 4'd7, 32'h18, 8'hFF, 64'h1111, 64'h0, 1'b0, 0);
        do_txn("rd_half_misal", 3'd4, 2'd1, 4'd6, 32'h23, 8'h0C, 64'h0, 64'h0, 1'b0, 0);
        do_txn("wr_regerr", 3'd0, 2'd0, 4'd9, 32'h1F, 8'h80, 64'h77, 64'h0, 1'b1, 0);
        do_txn("rd_bp", 3'd4, 2'd3, 4'd4, 32'hA0, 8'hFF, 64'h0, 64'h0BAD_F00D_0000_0042, 1'b1, 10);

        // Reset while in ACCESS drops the transaction
        wait_a_ready("rst_mid");
        tl_a_valid_i   = 1'b1;
        tl_a_opcode_i  = 3'd4;
        tl_a_size_i    = 2'd3;
        tl_a_source_i  = 4'd8;
        tl_a_address_i = 32'h40;
        reg_rdata_i    = 64'h5555;
        @(posedge clk);
        @(negedge clk);
        tl_a_valid_i = 1'b0;
        chk("rst_mid_re", 64'(reg_re_o), 64'd1);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("rst_mid_a_ready", 64'(tl_a_ready_o), 64'd0);
        chk("rst_mid_d_valid", 64'(tl_d_valid_o), 64'd0);
        chk("rst_mid_re_off", 64'(reg_re_o), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        reg_rdata_i = '0;
        @(negedge clk);
        chk("rst_mid_rel_a_ready", 64'(tl_a_ready_o), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("rst_mid_no_rsp", 64'(tl_d_valid_o), 64'd0);
            @(negedge clk);
        end

        do_txn("rd_after_rst", 3'd4, 2'd3, 4'd2, 32'h48, 8'hFF, 64'h0, 64'hCAFE_0000_BEEF_0001, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_llki_tlul_reg_adapter
`default_nettype wire
